data_memory_ctrl: RTL and testbench

- Parametrised, synchronous, word-organised data memory for the processor datapath, with byte enables, configurable wait states and a ready/valid handshake.
- Sits between the ALU address output and the write-back mux.
- Replaces the fixed 32-bit combinational data-memory stub with a real storage array and registered read data.
- Flags out-of-range and misaligned accesses instead of silently returning data.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 39 +++
 rtl/data_memory_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
// Holds the controller state encoding, the request op encoding and a
// log2 helper that is used to size index fields from the parameters.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int log2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage array for the data memory controller.
// Ports:
//   clk   - clock, writes and reads on the rising edge
//   we    - write enable for the whole word
//   waddr - word index of the write
//   wbe   - per byte-lane write enables (lane i = bits 8*i+7:8*i)
//   wdata - write data
//   raddr - word index of the read
//   rdata - registered read data (mem[raddr] of the previous edge)
// The array carries no reset: contents survive a controller reset.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX        = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IDX-1:0]          waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IDX-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Synchronous read every cycle plus byte-lane masked write.
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
    if (we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wbe[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: accepts one read or write request while idle,
// optionally stalls for WAIT_STATES cycles, then performs the access with an
// address check and reports completion through one-cycle pulses.
// Ports:
//   clk           - clock
//   Reset         - asynchronous active-low reset
//   MemoryAddress - byte address of the request
//   DataIn        - write data
//   ByteEn        - write byte enables, bit i enables byte lane i
//   memRD / memWD - read / write request (read wins when both are high)
//   DataOut       - registered read data, held until the next read completes
//   Ready         - high when a new request can be accepted
//   DataValid     - one-cycle pulse, DataOut updated by a completed read
//   AddrErr       - one-cycle pulse, the accepted request was rejected
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [ADDR_WIDTH-1:0]   MemoryAddress,
  input  logic [DATA_WIDTH-1:0]   DataIn,
  input  logic [DATA_WIDTH/8-1:0] ByteEn,
  input  logic                    memRD,
  input  logic                    memWD,
  output logic [DATA_WIDTH-1:0]   DataOut,
  output logic                    Ready,
  output logic                    DataValid,
  output logic                    AddrErr
);

  localparam int NBE = DATA_WIDTH / 8;
  localparam int OFS = log2_f(NBE);
  localparam int IDX = log2_f(DEPTH);

  // Address bits that must be zero: the in-word byte offset and everything
  // above the top word-index bit.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    (ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] RANGE_MASK =
    ~((ADDR_WIDTH'(1) << (OFS + IDX)) - ADDR_WIDTH'(1));
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [3:0]              cnt_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [NBE-1:0]          be_r;
  op_t                     op_r;
  logic [DATA_WIDTH-1:0]   dout_r;
  logic                    ready_r;
  logic                    valid_r;
  logic                    err_r;

  logic                    addr_err_s;
  logic                    wr_en_s;
  logic [IDX-1:0]          rd_idx_s;
  logic [IDX-1:0]          wr_idx_s;
  logic [DATA_WIDTH-1:0]   rdata_s;

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (memRD || memWD) begin
          state_nx_s = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == LAST_WAIT) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Address check and array port steering. The array read is launched on the
  // edge that enters DONE, so while idle the index comes straight from the
  // request (needed when there are no wait states) and from the latch otherwise.
  always_comb begin
    addr_err_s = |(addr_r & (ALIGN_MASK | RANGE_MASK));
    wr_idx_s   = addr_r[OFS+IDX-1:OFS];
    wr_en_s    = (state_r == ST_DONE) && (op_r == OP_WR) && !addr_err_s;
    if (state_r == ST_IDLE) begin
      rd_idx_s = MemoryAddress[OFS+IDX-1:OFS];
    end else begin
      rd_idx_s = addr_r[OFS+IDX-1:OFS];
    end
  end

  // Request capture, wait counter and registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wdata_r <= '0;
      be_r    <= '0;
      op_r    <= OP_RD;
      dout_r  <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 4'd0;
          if (memRD || memWD) begin
            addr_r  <= MemoryAddress;
            wdata_r <= DataIn;
            be_r    <= ByteEn;
            op_r    <= memRD ? OP_RD : OP_WR;
            ready_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_r == LAST_WAIT) begin
            cnt_r <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_DONE: begin
          ready_r <= 1'b1;
          if (addr_err_s) begin
            err_r <= 1'b1;
            if (op_r == OP_RD) begin
              dout_r <= '0;
            end
          end else if (op_r == OP_RD) begin
            dout_r  <= rdata_s;
            valid_r <= 1'b1;
          end
        end
        default: begin
          ready_r <= 1'b1;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX       (IDX)
  ) u_array (
    .clk  (clk),
    .we   (wr_en_s),
    .waddr(wr_idx_s),
    .wbe  (be_r),
    .wdata(wdata_r),
    .raddr(rd_idx_s),
    .rdata(rdata_s)
  );

  assign DataOut   = dout_r;
  assign Ready     = ready_r;
  assign DataValid = valid_r;
  assign AddrErr   = err_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: index 0 is a WAIT_STATES=0 instance, index 1 uses
// WAIT_STATES=2. Stimulus pushes expected completions (kind, data, cycle);
// a negedge monitor pops and compares whenever DataValid or AddrErr pulses.
module tb_data_memory_ctrl;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] a    [2];
  logic [31:0] din  [2];
  logic [3:0]  be   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] dout [2];
  logic        rdy  [2];
  logic        dv   [2];
  logic        ae   [2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .Reset(Reset), .MemoryAddress(a[0]), .DataIn(din[0]), .ByteEn(be[0]),
    .memRD(rd[0]), .memWD(wr[0]), .DataOut(dout[0]), .Ready(rdy[0]),
    .DataValid(dv[0]), .AddrErr(ae[0]));

  data_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) dut2 (
    .clk(clk), .Reset(Reset), .MemoryAddress(a[1]), .DataIn(din[1]), .ByteEn(be[1]),
    .memRD(rd[1]), .memWD(wr[1]), .DataOut(dout[1]), .Ready(rdy[1]),
    .DataValid(dv[1]), .AddrErr(ae[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic mon(input int d);
    exp_t x;
    logic empty;
    if (dv[d] || ae[d]) begin
      chk1($sformatf("dut%0d_valid_err_exclusive", d), dv[d] & ae[d], 1'b0);
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_pulse: got DataValid=%b AddrErr=%b, expected no pulse (cycle %0d)",
                 d, dv[d], ae[d], cyc);
      end else begin
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk1($sformatf("dut%0d_err_kind", d), ae[d], x.err);
        chk1($sformatf("dut%0d_valid_kind", d), dv[d], !x.err);
        chk($sformatf("dut%0d_dataout", d), dout[d], x.data);
        chk($sformatf("dut%0d_latency_cycle", d), 32'(cyc), 32'(x.due));
      end
    end
  endtask

  // Monitor: compare every completion pulse against the scoreboard.
  always @(negedge clk) begin
    if (Reset === 1'b1) begin
      mon(0);
      mon(1);
    end
  end

  // Issue one request at a negedge; expects to be called at a negedge.
  task automatic issue(input int d, input logic r, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] b,
                       input logic xerr, input logic [31:0] xdata, input logic push);
    int   n;
    int   lat;
    exp_t x;
    n   = 0;
    lat = (d == 0) ? 1 : 3;
    while (!rdy[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[d]) chk1($sformatf("dut%0d_ready_timeout", d), rdy[d], 1'b1);
    a[d] = addr; din[d] = data; be[d] = b; rd[d] = r; wr[d] = w;
    @(posedge clk);
    #1;
    if (push) begin
      x.err = xerr; x.data = xdata; x.due = cyc + lat;
      if (d == 0) q0.push_back(x);
      else q1.push_back(x);
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk1($sformatf("dut%0d_ready_k%0d", d, k), rdy[d], k == lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t x;
    for (int d = 0; d < 2; d++) begin
      a[d] = 32'd0; din[d] = 32'd0; be[d] = 4'd0; rd[d] = 1'b0; wr[d] = 1'b0;
    end
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk1("rst_ready", rdy[d], 1'b1);
      chk("rst_dataout", dout[d], 32'd0);
      chk1("rst_datavalid", dv[d], 1'b0);
      chk1("rst_addrerr", ae[d], 1'b0);
    end
    Reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of a write's wait period must abort it.
    issue(1, 1'b0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b1);
    a[1] = 32'h10; din[1] = 32'hDEADBEEF; be[1] = 4'hF; wr[1] = 1'b1;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    chk1("abort_ready_async", rdy[1], 1'b1);
    chk("abort_dataout_cleared", dout[1], 32'd0);
    chk1("abort_datavalid", dv[1], 1'b0);
    chk1("abort_addrerr", ae[1], 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    issue(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h12345678, 1'b1);

    // Full write then read, latency and Ready checked inside issue.
    issue(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11223344, 1'b1);
    // Partial byte-lane write.
    issue(1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h11BB33DD, 1'b1);
    // Misaligned and out-of-range reads.
    issue(1, 1'b1, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    issue(1, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
    // Read wins over a simultaneous write.
    issue(1, 1'b0, 1'b1, 32'h30, 32'h9, 4'hF, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b1, 32'h30, 32'h5, 4'hF, 1'b0, 32'h9, 1'b1);
    issue(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h9, 1'b1);
    // Errored write leaves DataOut alone; ByteEn=0 write is a no-op.
    issue(1, 1'b0, 1'b1, 32'h31, 32'h77, 4'hF, 1'b1, 32'h9, 1'b1);
    issue(1, 1'b0, 1'b1, 32'h30, 32'hFF, 4'h0, 1'b0, 32'h0, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h9, 1'b1);

    // Zero wait states: setup writes, then back-to-back held reads.
    issue(0, 1'b0, 1'b1, 32'h0, 32'hCAFE0000, 4'hF, 1'b0, 32'h0, 1'b0);
    issue(0, 1'b0, 1'b1, 32'h4, 32'h0000F00D, 4'hF, 1'b0, 32'h0, 1'b0);
    a[0] = 32'h0; rd[0] = 1'b1;
    @(posedge clk);
    #1;
    x.err = 1'b0; x.data = 32'hCAFE0000; x.due = cyc + 1;
    q0.push_back(x);
    a[0] = 32'h4;
    @(negedge clk);
    chk1("b2b_ready_low", rdy[0], 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk1("b2b_ready_high", rdy[0], 1'b1);
    @(posedge clk);
    #1;
    x.err = 1'b0; x.data = 32'h0000F00D; x.due = cyc + 1;
    q0.push_back(x);
    rd[0] = 1'b0;

    repeat (5) @(negedge clk);
    chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
    chk("dut2_queue_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
